// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: prescaled four-phase traffic light sequencer with
// cross-request green shortening. Optional pedestrian extension is enabled by
// defining TRAFFIC_PHASE_TIMER_PED_EN (adds ped_req / ped_walk).
module traffic_phase_timer #(
    parameter int unsigned PRESCALE     = 10,
    parameter int unsigned GREEN_TICKS  = 8,
    parameter int unsigned YELLOW_TICKS = 3,
    parameter int unsigned MIN_GREEN    = 2,
    parameter int unsigned PED_TICKS    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hold,
    input  logic       ew_req,
    input  logic       ns_req,
`ifdef TRAFFIC_PHASE_TIMER_PED_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic       advance,
    output logic [1:0] phase,
    output logic [7:0] remaining
);

    localparam int unsigned PW = 16;
    localparam int unsigned RW = 8;

    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [RW-1:0] GREEN_LD  = RW'(GREEN_TICKS);
    localparam logic [RW-1:0] YELLOW_LD = RW'(YELLOW_TICKS);
    localparam logic [RW-1:0] MIN_LD    = RW'(MIN_GREEN);
    localparam logic [RW-1:0] EXT_LD    = RW'(GREEN_TICKS + PED_TICKS);

    typedef enum logic [1:0] {
        PH_NS_GREEN  = 2'd0,
        PH_NS_YELLOW = 2'd1,
        PH_EW_GREEN  = 2'd2,
        PH_EW_YELLOW = 2'd3
    } phase_e;

    logic [PW-1:0] presc_q, presc_d;
    phase_e        phase_q, phase_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          adv_q, adv_d;
    logic          tick_c;
    logic          cross_c;
    logic          adv_green_c;
    logic          ped_load_c;
    logic          ext_c;

    assign tick_c = en && !hold && (presc_q == PRESC_MAX);

    // Prescaler: cleared when disabled, frozen on hold, wraps after the tick.
    always_comb begin
        presc_d = presc_q;
        if (!en) begin
            presc_d = '0;
        end else if (!hold) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
        end
    end

    // Phase timer: tick decrement/advance has priority over the cross-request clamp.
    always_comb begin
        phase_d     = phase_q;
        rem_d       = rem_q;
        adv_d       = 1'b0;
        adv_green_c = 1'b0;
        cross_c     = ((phase_q == PH_NS_GREEN) && ew_req) ||
                      ((phase_q == PH_EW_GREEN) && ns_req);
        if (tick_c) begin
            if (rem_q > RW'(1)) begin
                rem_d = rem_q - RW'(1);
            end else begin
                adv_d   = 1'b1;
                phase_d = phase_e'(phase_q + 2'd1);
                if ((phase_d == PH_NS_GREEN) || (phase_d == PH_EW_GREEN)) begin
                    adv_green_c = 1'b1;
                    rem_d       = ped_load_c ? EXT_LD : GREEN_LD;
                end else begin
                    rem_d = YELLOW_LD;
                end
            end
        end else if (cross_c && !hold && !ext_c && (rem_q > MIN_LD)) begin
            rem_d = MIN_LD;
        end
    end

`ifdef TRAFFIC_PHASE_TIMER_PED_EN
    logic pend_q, pend_d;
    logic walk_q, walk_d;

    assign ped_load_c = pend_q;
    assign ext_c      = walk_q;
    assign ped_walk   = walk_q;

    // Pedestrian state: sticky pending flag (a new request beats the clear),
    // walk held for the whole extended green.
    always_comb begin
        pend_d = pend_q | ped_req;
        walk_d = walk_q;
        if (adv_d) begin
            walk_d = adv_green_c && pend_q;
            if (adv_green_c && pend_q) begin
                pend_d = ped_req;
            end
        end
    end

    // Pedestrian state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            walk_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            walk_q <= walk_d;
        end
    end
`else
    assign ped_load_c = 1'b0;
    assign ext_c      = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            phase_q <= PH_NS_GREEN;
            rem_q   <= GREEN_LD;
            adv_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            rem_q   <= rem_d;
            adv_q   <= adv_d;
        end
    end

    assign advance   = adv_q;
    assign phase     = phase_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with PRESCALE=2, GREEN_TICKS=4,
// YELLOW_TICKS=2, MIN_GREEN=1, PED_TICKS=3. Edge numbers count rising edges
// after reset release (edge 1 is the first); outputs are sampled 1 ns later.
module tb_traffic_phase_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       hold;
    logic       ew_req;
    logic       ns_req;
    logic       advance;
    logic [1:0] phase;
    logic [7:0] remaining;
`ifdef TRAFFIC_PHASE_TIMER_PED_EN
    logic       ped_req;
    logic       ped_walk;
`endif

    int errors = 0;
    int checks = 0;
    int ecount = 0;

    always #5 clk = ~clk;

    traffic_phase_timer #(
        .PRESCALE    (2),
        .GREEN_TICKS (4),
        .YELLOW_TICKS(2),
        .MIN_GREEN   (1),
        .PED_TICKS   (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .hold     (hold),
        .ew_req   (ew_req),
        .ns_req   (ns_req),
`ifdef TRAFFIC_PHASE_TIMER_PED_EN
        .ped_req  (ped_req),
        .ped_walk (ped_walk),
`endif
        .advance  (advance),
        .phase    (phase),
        .remaining(remaining)
    );

    task automatic step();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        en     = 1'b1;
        hold   = 1'b0;
        ew_req = 1'b0;
        ns_req = 1'b0;
`ifdef TRAFFIC_PHASE_TIMER_PED_EN
        ped_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        ecount = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1; hold = 1'b0; ew_req = 1'b0; ns_req = 1'b0;
`ifdef TRAFFIC_PHASE_TIMER_PED_EN
        ped_req = 1'b0;
`endif
        #1;
        repeat (2) @(negedge clk);
        checks++;
        if (phase !== 2'd0 || remaining !== 8'd4 || advance !== 1'b0) begin
            errors++;
            $display("FAIL reset: phase=%0d rem=%0d adv=%b expected phase=0 rem=4 adv=0",
                     phase, remaining, advance);
        end
`ifdef TRAFFIC_PHASE_TIMER_PED_EN
        checks++;
        if (ped_walk !== 1'b0) begin
            errors++;
            $display("FAIL reset_walk: ped_walk=%b expected 0", ped_walk);
        end
`endif
    endtask

    task automatic test_free_run();
        logic       exp_adv;
        logic       do_chk;
        logic [1:0] exp_ph;
        logic [7:0] exp_rem;
        do_reset();
        for (int e = 1; e <= 26; e++) begin
            step();
            exp_adv = (e == 8) || (e == 12) || (e == 20) || (e == 24);
            checks++;
            if (advance !== exp_adv) begin
                errors++;
                $display("FAIL free_run_adv edge %0d: adv=%b expected %b", e, advance, exp_adv);
            end
            do_chk = 1'b1;
            exp_ph = 2'd0; exp_rem = 8'd0;
            case (e)
                1:  begin exp_ph = 2'd0; exp_rem = 8'd4; end
                2:  begin exp_ph = 2'd0; exp_rem = 8'd3; end
                6:  begin exp_ph = 2'd0; exp_rem = 8'd1; end
                8:  begin exp_ph = 2'd1; exp_rem = 8'd2; end
                10: begin exp_ph = 2'd1; exp_rem = 8'd1; end
                12: begin exp_ph = 2'd2; exp_rem = 8'd4; end
                20: begin exp_ph = 2'd3; exp_rem = 8'd2; end
                24: begin exp_ph = 2'd0; exp_rem = 8'd4; end
                default: do_chk = 1'b0;
            endcase
            if (do_chk) begin
                checks++;
                if (phase !== exp_ph || remaining !== exp_rem) begin
                    errors++;
                    $display("FAIL free_run_state edge %0d: phase=%0d rem=%0d expected phase=%0d rem=%0d",
                             e, phase, remaining, exp_ph, exp_rem);
                end
            end
        end
    endtask

    task automatic test_cross();
        do_reset();
        step();                       // edge 1
        ew_req = 1'b1;
        step();                       // edge 2: tick wins over the clamp
        checks++;
        if (remaining !== 8'd3) begin
            errors++;
            $display("FAIL cross_tick_wins: rem=%0d expected 3", remaining);
        end
        step();                       // edge 3: clamp to MIN_GREEN
        checks++;
        if (remaining !== 8'd1 || advance !== 1'b0) begin
            errors++;
            $display("FAIL cross_clamp: rem=%0d adv=%b expected rem=1 adv=0", remaining, advance);
        end
        ew_req = 1'b0;
        step();                       // edge 4: advance
        checks++;
        if (advance !== 1'b1 || phase !== 2'd1 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL cross_advance: adv=%b phase=%0d rem=%0d expected adv=1 phase=1 rem=2",
                     advance, phase, remaining);
        end
        repeat (4) step();            // edge 8: into phase 2
        checks++;
        if (phase !== 2'd2 || remaining !== 8'd4 || advance !== 1'b1) begin
            errors++;
            $display("FAIL cross_into_ew: phase=%0d rem=%0d adv=%b expected phase=2 rem=4 adv=1",
                     phase, remaining, advance);
        end
        ns_req = 1'b1;
        step();                       // edge 9: NS request clamps EW green
        checks++;
        if (remaining !== 8'd1) begin
            errors++;
            $display("FAIL cross_ns_clamp: rem=%0d expected 1", remaining);
        end
        ns_req = 1'b0;
        step();                       // edge 10
        checks++;
        if (advance !== 1'b1 || phase !== 2'd3 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL cross_ns_advance: adv=%b phase=%0d rem=%0d expected adv=1 phase=3 rem=2",
                     advance, phase, remaining);
        end
    endtask

    task automatic test_ignore();
        do_reset();
        ns_req = 1'b1;                // opposite-direction request in phase 0
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 3) begin
                checks++;
                if (remaining !== 8'd3) begin
                    errors++;
                    $display("FAIL ignore_ns_in_p0: rem=%0d expected 3", remaining);
                end
            end
            if (e == 5) begin
                checks++;
                if (remaining !== 8'd2) begin
                    errors++;
                    $display("FAIL ignore_ns_in_p0_e5: rem=%0d expected 2", remaining);
                end
            end
        end
        ns_req = 1'b0;
        step();                       // edge 8: advance into yellow
        ew_req = 1'b1;
        ns_req = 1'b1;
        step();                       // edge 9: yellow ignores both
        checks++;
        if (phase !== 2'd1 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL ignore_in_yellow: phase=%0d rem=%0d expected phase=1 rem=2",
                     phase, remaining);
        end
        ew_req = 1'b0;
        ns_req = 1'b0;
    endtask

    task automatic test_hold();
        logic exp_adv;
        do_reset();
        for (int e = 1; e <= 13; e++) begin
            if (e == 3) hold = 1'b1;
            if (e == 8) hold = 1'b0;
            step();
            exp_adv = (e == 13);
            checks++;
            if (advance !== exp_adv) begin
                errors++;
                $display("FAIL hold_adv edge %0d: adv=%b expected %b", e, advance, exp_adv);
            end
            if (e >= 3 && e <= 8) begin
                checks++;
                if (remaining !== 8'd3 || phase !== 2'd0) begin
                    errors++;
                    $display("FAIL hold_frozen edge %0d: phase=%0d rem=%0d expected phase=0 rem=3",
                             e, phase, remaining);
                end
            end
        end
        checks++;
        if (phase !== 2'd1 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL hold_after: phase=%0d rem=%0d expected phase=1 rem=2", phase, remaining);
        end
    endtask

    task automatic test_enable();
        do_reset();
        repeat (3) step();            // edge 3: rem=3, prescaler mid-count
        en = 1'b0;
        for (int e = 4; e <= 23; e++) begin
            step();
            checks++;
            if (advance !== 1'b0 || remaining !== 8'd3) begin
                errors++;
                $display("FAIL enable_off edge %0d: adv=%b rem=%0d expected adv=0 rem=3",
                         e, advance, remaining);
            end
        end
        en = 1'b1;
        step();                       // prescaler restarts from 0: no tick yet
        checks++;
        if (remaining !== 8'd3) begin
            errors++;
            $display("FAIL enable_restart: rem=%0d expected 3", remaining);
        end
        step();
        checks++;
        if (remaining !== 8'd2) begin
            errors++;
            $display("FAIL enable_first_tick: rem=%0d expected 2", remaining);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (14) step();
        checks++;
        if (phase !== 2'd2 || remaining !== 8'd3) begin
            errors++;
            $display("FAIL reset_mid_pre: phase=%0d rem=%0d expected phase=2 rem=3", phase, remaining);
        end
        @(posedge clk);               // edge 15
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (phase !== 2'd0 || remaining !== 8'd4 || advance !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: phase=%0d rem=%0d adv=%b expected phase=0 rem=4 adv=0",
                     phase, remaining, advance);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (advance !== 1'b0 || remaining !== 8'd4) begin
            errors++;
            $display("FAIL reset_mid_held: adv=%b rem=%0d expected adv=0 rem=4", advance, remaining);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        ecount = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (advance !== (e == 8)) begin
                errors++;
                $display("FAIL reset_mid_restart edge %0d: adv=%b expected %b", e, advance, (e == 8));
            end
        end
        checks++;
        if (phase !== 2'd1 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL reset_mid_phase: phase=%0d rem=%0d expected phase=1 rem=2", phase, remaining);
        end
    endtask

`ifdef TRAFFIC_PHASE_TIMER_PED_EN
    task automatic test_ped();
        int walk_cycles;
        walk_cycles = 0;
        do_reset();
        repeat (9) step();            // edge 9: phase 1
        ped_req = 1'b1;
        step();                       // edge 10
        ped_req = 1'b0;
        step();                       // edge 11
        checks++;
        if (ped_walk !== 1'b0) begin
            errors++;
            $display("FAIL ped_walk_early: ped_walk=%b expected 0", ped_walk);
        end
        step();                       // edge 12: extended EW green
        checks++;
        if (phase !== 2'd2 || remaining !== 8'd7 || ped_walk !== 1'b1) begin
            errors++;
            $display("FAIL ped_load: phase=%0d rem=%0d walk=%b expected phase=2 rem=7 walk=1",
                     phase, remaining, ped_walk);
        end
        ns_req = 1'b1;
        walk_cycles = 1;
        for (int e = 13; e <= 26; e++) begin
            step();
            if (ped_walk === 1'b1) walk_cycles++;
            if (e == 13) begin
                checks++;
                if (remaining !== 8'd7) begin
                    errors++;
                    $display("FAIL ped_no_clamp: rem=%0d expected 7", remaining);
                end
            end
        end
        ns_req = 1'b0;
        checks++;
        if (walk_cycles !== 14 || phase !== 2'd3 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL ped_walk_len: walk_cycles=%0d phase=%0d rem=%0d expected 14 / 3 / 2",
                     walk_cycles, phase, remaining);
        end
        repeat (4) step();            // edge 30: plain green, flag consumed
        checks++;
        if (phase !== 2'd0 || remaining !== 8'd4 || ped_walk !== 1'b0) begin
            errors++;
            $display("FAIL ped_flag_cleared: phase=%0d rem=%0d walk=%b expected 0 / 4 / 0",
                     phase, remaining, ped_walk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_cross();
        test_ignore();
        test_hold();
        test_enable();
        test_reset_mid();
`ifdef TRAFFIC_PHASE_TIMER_PED_EN
        test_ped();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_timer.md
TRAFFIC_PHASE_TIMER -- requirements
Module: traffic_phase_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 10: clk cycles per timing tick, range 1..65535.
REQ-002 SHALL have parameter GREEN_TICKS, default 8: ticks per green phase (phases 0, 2).
REQ-003 SHALL have parameter YELLOW_TICKS, default 3: ticks per yellow phase (phases 1, 3), range >=1.
REQ-004 SHALL have parameter MIN_GREEN, default 2: floor on a green phase cut short by a cross request, 1 <= MIN_GREEN < GREEN_TICKS.
REQ-005 SHALL have parameter PED_TICKS, default 4: green extension for a pedestrian request; GREEN_TICKS+PED_TICKS <= 255.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port en, input, 1 bit: run enable; low stops the prescaler.
REQ-009 SHALL have port hold, input, 1 bit: manual freeze of prescaler and phase timer.
REQ-010 SHALL have port ew_req, input, 1 bit: EW vehicle waiting, acted on in phase 0.
REQ-011 SHALL have port ns_req, input, 1 bit: NS vehicle waiting, acted on in phase 2.
REQ-012 SHALL have port advance, output, 1 bit: registered one-cycle pulse that steps the downstream light controller.
REQ-013 SHALL have port phase, output, 2 bits: current phase, 0 NS-green, 1 NS-yellow, 2 EW-green, 3 EW-yellow.
REQ-014 SHALL have port remaining, output, 8 bits: ticks left in the current phase.

Function
REQ-015 SHALL count the prescaler 0..PRESCALE-1 while en=1 and hold=0, and raise an internal tick in the cycle the count equals PRESCALE-1, then wrap the count to 0.
REQ-016 SHALL hold the prescaler at its value while hold=1, and force it to 0 while en=0.
REQ-017 SHALL decrement remaining on each tick while remaining > 1.
REQ-018 SHALL, on a tick with remaining == 1, assert advance for exactly one cycle, step phase (3 wraps to 0), and load remaining with the new phase's duration.
REQ-019 SHALL, when phase is 0 with ew_req=1, or phase is 2 with ns_req=1, and remaining > MIN_GREEN and no tick that cycle, load remaining with MIN_GREEN on the next edge.
REQ-020 SHALL let the tick decrement win when a cross request and a tick occur together; the request is re-evaluated on the next cycle.
REQ-021 SHALL ignore ew_req and ns_req in yellow phases and in the opposite green phase.
REQ-022 SHALL keep advance low at all times other than REQ-018, including while hold=1 or en=0.

Reset
REQ-023 SHALL, while rst_n=0 and independent of clk, force phase=0, remaining=GREEN_TICKS, prescaler=0, advance=0, and all pedestrian state to 0.
REQ-024 SHALL, when rst_n is asserted mid-phase, abandon the phase without emitting advance.

Configuration
REQ-025 SHALL, when macro TRAFFIC_PHASE_TIMER_PED_EN is defined, add input ped_req (1 bit) and output ped_walk (1 bit).
REQ-026 SHALL, with TRAFFIC_PHASE_TIMER_PED_EN defined, latch ped_req into a sticky pending flag; a set and a clear in the same cycle leave the flag set.
REQ-027 SHALL, with TRAFFIC_PHASE_TIMER_PED_EN defined and the flag set, load GREEN_TICKS+PED_TICKS on advance into phase 0 or 2, clear the flag, and hold ped_walk high for that whole green phase.
REQ-028 SHALL, with TRAFFIC_PHASE_TIMER_PED_EN defined, suppress the REQ-019 clamp during an extended green.
REQ-029 SHALL, without TRAFFIC_PHASE_TIMER_PED_EN defined, omit ped_req, ped_walk and the pending flag, with all other behaviour identical.

Verification
Bench parameters: PRESCALE=2, GREEN_TICKS=4, YELLOW_TICKS=2, MIN_GREEN=1, PED_TICKS=3.
REQ-030 SHALL cover free run: rst_n release, en=1, all requests 0 -> advance pulses at edges 8, 12, 20, 24; phase 0->1->2->3->0; remaining reloads 2, 4, 2, 4.
REQ-031 SHALL cover the cross request: ew_req=1 in cycle 1 of phase 0 -> remaining=1 next edge; advance at edge 4; ns_req asserted in phase 0 -> no effect.
REQ-032 SHALL cover hold: hold=1 for 5 cycles starting at edge 3 -> first advance moves from edge 8 to edge 13; remaining and phase frozen during hold.
REQ-033 SHALL cover reset mid-phase: rst_n low at edge 15 (phase 2) -> phase=0, remaining=4, advance=0 immediately; after release, free run restarts per REQ-030.
REQ-034 SHALL cover the pedestrian option (TRAFFIC_PHASE_TIMER_PED_EN defined): ped_req pulse in phase 1 -> phase 2 loads remaining=7, ped_walk high for 14 cycles, flag cleared; ns_req ignored throughout.
REQ-035 SHALL cover enable: en=0 for 20 cycles -> prescaler 0, no advance, remaining unchanged.
